// File: rtl/uart_rx_axis.sv
// uart_rx_axis: UART receiver packing bytes into W_OUT-bit words on a
// valid/ready master port, with frame-error and overrun pulses.
// Ports: clk, rstn (async, active-low), rx (raw UART line),
//   m_ready (in), m_valid / m_data[W_OUT] / m_frame_err / m_overrun (out).
// Optional: define UART_RX_AXIS_PARITY_EN for an even-parity bit per frame.
module uart_rx_axis #(
  parameter int CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 8*8*3+8*4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic             m_frame_err,
  output logic             m_overrun
);

  localparam int NB  = (W_OUT + BITS_PER_WORD - 1) / BITS_PER_WORD;
  localparam int AW  = NB * BITS_PER_WORD;
  localparam int CW  = $clog2(CLOCKS_PER_PULSE);
  localparam int BCW = $clog2(BITS_PER_WORD + 1);
  localparam int NBW = $clog2(NB + 1);

  localparam logic [CW-1:0]  HALF_M1   = CW'(CLOCKS_PER_PULSE/2 - 1);
  localparam logic [CW-1:0]  FULL_M1   = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BITS_PER_WORD - 1);
  localparam logic [NBW-1:0] BYTE_LAST = NBW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_AXIS_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                     state_q, state_d;
  logic                       rx_m, rx_s;
  logic [CW-1:0]              cnt_q;
  logic [BCW-1:0]             bit_q;
  logic [BITS_PER_WORD-1:0]   shift_q;
  logic [NBW-1:0]             byte_q;
  logic [AW-1:0]              asm_q, word_full;
  logic                       tick, sample_bit, commit, ferr;
  logic                       par_ok, complete;

`ifdef UART_RX_AXIS_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_q <= 1'b0;
    end else if (state_q == PARITY && tick) begin
      par_q <= rx_s;
    end
  end

  // Even parity: data bits xor parity bit must be zero.
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  assign tick = (state_q == START) ? (cnt_q == HALF_M1)
                                   : (cnt_q == FULL_M1);

  always_comb begin
    state_d    = state_q;
    sample_bit = 1'b0;
    commit     = 1'b0;
    ferr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        // High at mid-start means a glitch: drop it silently.
        if (tick) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          sample_bit = 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_AXIS_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_AXIS_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s && par_ok) begin
            commit  = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Assembly register with the byte being committed merged in.
  always_comb begin
    word_full = asm_q;
    word_full[byte_q*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
  end

  assign complete = commit && (byte_q == BYTE_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      asm_q       <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_frame_err <= 1'b0;
      m_overrun   <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      state_q <= state_d;

      if (state_q == IDLE || state_q == WAIT_HIGH || tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == START) begin
        bit_q <= '0;
      end else if (sample_bit) begin
        bit_q <= bit_q + 1'b1;
      end

      if (sample_bit) begin
        shift_q <= {rx_s, shift_q[BITS_PER_WORD-1:1]};
      end

      if (commit) begin
        asm_q  <= word_full;
        byte_q <= complete ? '0 : byte_q + 1'b1;
      end else if (ferr) begin
        byte_q <= '0;
      end

      m_frame_err <= ferr;
      m_overrun   <= complete && m_valid && !m_ready;

      // Single-entry output: a held, unaccepted word wins over a new one.
      if (complete && (!m_valid || m_ready)) begin
        m_valid <= 1'b1;
        m_data  <= word_full[W_OUT-1:0];
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed plus randomized UART frames against a
// queue-based word model; one compare process checks every handshake.
module tb_uart_rx_axis;

  localparam int CPP = 8;
  localparam int BPW = 8;
  localparam int W   = 16;
  localparam int NB  = 2;
`ifdef UART_RX_AXIS_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FB = 1 + BPW + PB;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         rx = 1'b1;
  logic         m_ready = 1'b0;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_frame_err;
  logic         m_overrun;

  uart_rx_axis #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD(BPW),
    .W_OUT(W)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rx(rx),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_frame_err(m_frame_err),
    .m_overrun(m_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: bytes in order, words into a 1-deep queue.
  logic [W-1:0]      exp_q[$];
  logic [NB*BPW-1:0] mword = '0;
  int                mcnt = 0;
  int                exp_ferr = 0;
  int                exp_ovr = 0;

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (good) begin
      mword[mcnt*BPW +: BPW] = b;
      mcnt++;
      if (mcnt == NB) begin
        mcnt = 0;
        if (exp_q.size() > 0) exp_ovr++;
        else exp_q.push_back(mword[W-1:0]);
      end
    end else begin
      mcnt = 0;
      exp_ferr++;
    end
  endfunction

  // Compare process: observed pulses, handshakes, stall stability.
  int           ferr_seen = 0;
  int           ovr_seen = 0;
  int           valid_cnt = 0;
  int           vcyc = 0;
  logic [W-1:0] last_hs = '0;
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [W-1:0] pd = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (m_frame_err) ferr_seen++;
      if (m_overrun) ovr_seen++;
      if (m_valid) valid_cnt++;
      if (m_valid && !pv) vcyc = cyc;
      if (pv && !pr) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === pd)) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=%0h expected v=1 d=%0h",
                   m_valid, m_data, pd);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL handshake: got unexpected word %0h expected none",
                   m_data);
        end else begin
          logic [W-1:0] w;
          w = exp_q.pop_front();
          if (m_data !== w) begin
            errors++;
            $display("FAIL handshake: got %0h expected %0h", m_data, w);
          end
        end
        last_hs = m_data;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPP);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop = 1'b1,
                            input bit par_bad = 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < BPW; i++) send_bit(b[i]);
`ifdef UART_RX_AXIS_PARITY_EN
    send_bit(^b ^ par_bad);
`endif
    model_frame(b, stop && !par_bad);
    send_bit(stop);
  endtask

  task automatic check_out_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_data"}, {16'd0, m_data}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, m_frame_err}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, m_overrun}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, d, hs0;
    logic [7:0] b;
    int k;

    tick(3);
    check_out_zero("reset");
    rstn = 1'b1;
    tick(4);
    chk("post_reset_valid", {31'd0, m_valid}, 32'd0);

    // Two bytes into one word, first byte in the LSBs.
    m_ready = 1'b1;
    valid_cnt = 0;
    send_frame(8'h34);
    s = cyc;
    send_frame(8'h12);
    tick(4);
    d = vcyc - s;
    chk("t1_valid_cycles", valid_cnt, 1);
    chk("t1_word", {16'd0, last_hs}, 32'h1234);
    chk("t1_latency", {31'd0, (d >= FB*CPP + CPP/2 && d <= (FB+1)*CPP)}, 1);

    // Backpressure and overrun.
    m_ready = 1'b0;
    send_frame(8'hAA);
    send_frame(8'hBB);
    tick(4);
    chk("t2_held_valid", {31'd0, m_valid}, 1);
    chk("t2_held_data", {16'd0, m_data}, 32'hBBAA);
    send_frame(8'hCC);
    send_frame(8'hDD);
    tick(4);
    chk("t2_still_data", {16'd0, m_data}, 32'hBBAA);
    chk("t2_ovr_count", ovr_seen, 1);
    m_ready = 1'b1;
    tick(2);
    chk("t2_drained", {31'd0, m_valid}, 0);
    chk("t2_accepted", {16'd0, last_hs}, 32'hBBAA);

    // Frame error discards the partial word.
    send_frame(8'h34);
    send_frame(8'h00, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_frame(8'h56);
    send_frame(8'h78);
    tick(4);
    chk("t3_ferr_count", ferr_seen, 1);
    chk("t3_word", {16'd0, last_hs}, 32'h7856);

    // Short glitch: nothing received, receiver stays usable.
    hs0 = valid_cnt;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3*CPP);
    chk("t4_no_ferr", ferr_seen, 1);
    chk("t4_no_word", valid_cnt, hs0);
    send_frame(8'h9A);
    send_frame(8'hBC);
    tick(4);
    chk("t4_word", {16'd0, last_hs}, 32'hBC9A);

    // Reset mid-frame loses the held word and the partial word.
    m_ready = 1'b0;
    send_frame(8'h11);
    send_frame(8'h22);
    send_frame(8'h33);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rstn = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    mcnt = 0;
    tick(2);
    check_out_zero("t5_in_reset");
    rstn = 1'b1;
    tick(2*CPP);
    m_ready = 1'b1;
    send_frame(8'h01);
    send_frame(8'h02);
    tick(4);
    chk("t5_word", {16'd0, last_hs}, 32'h0201);

`ifdef UART_RX_AXIS_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    tick(2);
    chk("t6_par_ferr", ferr_seen, 2);
    send_frame(8'h07);
    send_frame(8'h08);
    tick(4);
    chk("t6_word", {16'd0, last_hs}, 32'h0807);
`endif

    // Randomized traffic; ready only changes between frames.
    for (int n = 0; n < 80; n++) begin
      b = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 9);
      m_ready = ($urandom_range(0, 3) != 0);
      if (k == 0) begin
        send_frame(b, 1'b0);
        send_bit(1'b1);
      end else if (k == 1) begin
        rx = 1'b0;
        tick($urandom_range(1, 2));
        rx = 1'b1;
        tick(2*CPP);
`ifdef UART_RX_AXIS_PARITY_EN
      end else if (k == 2) begin
        send_frame(b, 1'b1, 1'b1);
        send_bit(1'b1);
`endif
      end else begin
        send_frame(b);
        tick($urandom_range(0, 2) * (CPP/2));
      end
    end

    m_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    chk("rand_drain", exp_q.size(), 0);
    chk("rand_ferr", ferr_seen, exp_ferr);
    chk("rand_ovr", ovr_seen, exp_ovr);
    chk("rand_idle_valid", {31'd0, m_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
# uart_rx_axis

UART receiver with an AXI-Stream-style master output and framing checks. It deserialises LSB-first UART bytes from `rx`, packs `ceil(W_OUT/BITS_PER_WORD)` bytes into one `W_OUT`-bit word and presents that word under a valid/ready handshake. It sits directly upstream of `axis_matvec_mul` and drives its `s_axis_kx_*` slave port. Unlike a valid-only receiver, it respects backpressure and reports framing and overrun errors.

## Interface
- `CLOCKS_PER_PULSE`, default 200_000_000/9600: `clk` cycles per UART bit; must be ≥ 4.
- `BITS_PER_WORD`, default 8: data bits per UART frame.
- `W_OUT`, default 8*8*3+8*4 = 224: output word width.
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: reset, asynchronous assert, active-low.
- `rx` in 1: UART line; idle high; asynchronous to `clk`.
- `m_ready` in 1: downstream ready.
- `m_valid` out 1: output word valid.
- `m_data` out W_OUT: assembled word; the first byte received occupies the LSBs.
- `m_frame_err` out 1: one-cycle pulse per frame error.
- `m_overrun` out 1: one-cycle pulse per dropped word.

## Operation
- Reset state: `m_valid`=0, `m_data`=0, `m_frame_err`=0, `m_overrun`=0, FSM in IDLE, byte count 0, synchroniser flops = 1.
- `rx` passes through a 2-flop synchroniser. All descriptions below refer to the synchronised signal `rx_s`.
- `NUM_BYTES` = ceil(W_OUT/BITS_PER_WORD). Byte k (0-based) lands in bits [k*BITS_PER_WORD +: BITS_PER_WORD]. Bits above W_OUT-1 in the last byte are discarded.
- FSM states:
  - IDLE → START on `rx_s`=0.
  - START: counts `CLOCKS_PER_PULSE/2` cycles, then samples `rx_s`. If 1 (glitch), return to IDLE with no error. If 0, go to DATA with the bit counter at 0.
  - DATA: every `CLOCKS_PER_PULSE` cycles, samples one bit, LSB first. After `BITS_PER_WORD` bits, go to PARITY if enabled, else STOP.
  - PARITY (only when the parity macro is defined): samples one bit after `CLOCKS_PER_PULSE` cycles.
  - STOP: samples after `CLOCKS_PER_PULSE` cycles.
    - Stop bit = 1 and parity OK: the byte is committed to the assembly register; byte count increments; go to IDLE.
    - Stop bit = 0 or parity bad: pulse `m_frame_err`, discard the partial word (byte count cleared), go to WAIT_HIGH.
  - WAIT_HIGH → IDLE on `rx_s`=1.
- Word completion: when the committed byte makes byte count = `NUM_BYTES`, byte count wraps to 0 and the word is offered to the output register.
- Output register (single entry):
  - Loads on completion if `m_valid`=0, or if `m_valid && m_ready` in the same cycle (simultaneous drain and load; `m_valid` stays 1).
  - If `m_valid && !m_ready` at completion, the new word is dropped, `m_overrun` pulses, and the held word is unchanged.
  - `m_valid && m_ready` with no completion clears `m_valid`. `m_data` holds its last value.
- `m_data` is stable while `m_valid && !m_ready`.
- Reset mid-frame or mid-word clears everything; partial bytes and words are lost, and the held output word is lost.

## Timing
- Sample point: mid-bit, at `CLOCKS_PER_PULSE/2` after the detected start edge plus n*`CLOCKS_PER_PULSE`, plus 2 cycles of synchroniser delay relative to the raw `rx`.
- Stop-bit sample to `m_valid`=1: 1 cycle (registered).
- Stop-bit sample to `m_frame_err`/`m_overrun` pulse: 1 cycle.
- The next start bit is accepted in the cycle after the stop sample, so back-to-back frames have no lost bits.
- Throughput: one word per `NUM_BYTES` frames. `m_ready` never stalls reception.

## Configuration
- `UART_RX_AXIS_PARITY_EN` defined: each frame carries an even-parity bit after the data bits. A mismatch is treated as a frame error. The frame is 1 start + `BITS_PER_WORD` + 1 parity + 1 stop bits.
- Undefined: no parity state; the frame is 1 start + `BITS_PER_WORD` + 1 stop bits. Parity logic is absent.

## Test plan
- `CLOCKS_PER_PULSE`=8, `W_OUT`=16, `m_ready`=1; send 0x34 then 0x12 → one `m_valid` pulse with `m_data`=0x1234, 1 cycle after the second stop sample.
- Hold `m_ready`=0 and send 0xAA,0xBB, then 0xCC,0xDD → `m_data`=0xBBAA stays stable, `m_overrun` pulses once, no `m_valid` drop. Then raise `m_ready` → word accepted, `m_valid`=0.
- Send 0x34, then a frame with stop bit 0 while `rx` is held low for 3 bits, then 0x56,0x78 → `m_frame_err` pulse; next `m_data`=0x7856; 0x34 never appears.
- Pull `rx` low for 2 cycles only → no byte, no error, FSM back in IDLE.
- Deassert `rstn` mid-DATA of the second byte, release, send 0x01,0x02 → `m_data`=0x0201; all outputs 0 during reset.
- With `UART_RX_AXIS_PARITY_EN`, send 0x07 with parity 0 (wrong) → `m_frame_err` pulse. With correct parity 1 → byte accepted.
